fetch_stage: RTL and testbench

Instruction fetch stage directly downstream of the program counter. It drives the synchronous instruction memory address from the PC value and registers the returned word into an instruction register (IR) for the decoder. On a taken jump or branch it flushes wrong-path fetches. It detects the halt word and raises a sticky done flag for the testbench and top level.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/start/jump control in, instruction memory port, IR and perf outputs.
// master is the PC/top-level side; slave is the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned D  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
) ();
  logic          start;
  logic [D-1:0]  pc_in;
  logic          jump_taken;
  logic [D-1:0]  imem_addr;
  logic [W-1:0]  imem_rdata;
  logic [W-1:0]  instr_out;
  logic [D-1:0]  instr_pc;
  logic          instr_valid;
  logic          done;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] bubble_count;

  modport master (
    output start, pc_in, jump_taken, imem_rdata,
    input  imem_addr, instr_out, instr_pc, instr_valid, done, instr_count, bubble_count
  );

  modport slave (
    input  start, pc_in, jump_taken, imem_rdata,
    output imem_addr, instr_out, instr_pc, instr_valid, done, instr_count, bubble_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: two-deep fetch pipeline (stage 1 tag + IR), jump flush, halt detect.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter int unsigned   D         = 10,
  parameter int unsigned   W         = 9,
  parameter logic [W-1:0]  HALT_WORD = '0,
  parameter int unsigned   CW        = 16
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e       state_q;
  logic         s1_valid_q;
  logic [D-1:0] s1_pc_q;
  logic [W-1:0] instr_q;
  logic [D-1:0] instr_pc_q;
  logic         instr_valid_q;
  logic         done_q;
  logic         halt_det;

  assign bus.imem_addr = bus.pc_in;

  assign halt_det = (state_q == StRun) && instr_valid_q && (instr_q == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      s1_valid_q    <= 1'b0;
      s1_pc_q       <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else if (bus.start) begin
      // IR contents are kept; only the valid bits are dropped on restart.
      state_q       <= StRun;
      s1_valid_q    <= 1'b0;
      s1_pc_q       <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          s1_valid_q    <= !bus.jump_taken && !halt_det;
          s1_pc_q       <= bus.pc_in;
          instr_q       <= bus.imem_rdata;
          instr_pc_q    <= s1_pc_q;
          instr_valid_q <= s1_valid_q && !bus.jump_taken && !halt_det;
          if (halt_det) begin
            state_q <= StHalt;
            done_q  <= 1'b1;
          end
        end
        default: begin
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.done        = done_q;

`ifdef FETCH_PERF_EN
  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [CW-1:0] instr_count_q, instr_count_d;
  logic [CW-1:0] bubble_count_q, bubble_count_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    instr_count_d  = instr_count_q;
    bubble_count_d = bubble_count_q;
    if (reset || bus.start) begin
      instr_count_d  = '0;
      bubble_count_d = '0;
    end else if (state_q == StRun) begin
      if (instr_valid_q) begin
        if (instr_count_q != CntMax) instr_count_d = instr_count_q + CntOne;
      end else begin
        if (bubble_count_q != CntMax) bubble_count_d = bubble_count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    instr_count_q  <= instr_count_d;
    bubble_count_q <= bubble_count_d;
  end

  assign bus.instr_count  = instr_count_q;
  assign bus.bubble_count = bubble_count_q;
`else
  assign bus.instr_count  = {CW{1'b0}};
  assign bus.bubble_count = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random programs, checked every cycle against
// a queue-based model of in-flight fetches.
module tb_fetch_stage;
  localparam int unsigned  D    = 10;
  localparam int unsigned  W    = 9;
  localparam int unsigned  CW   = 4;
  localparam logic [W-1:0] HALT = '0;
  localparam int           CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  fetch_stage_if #(.D(D), .W(W), .CW(CW)) bus ();

  fetch_stage #(.D(D), .W(W), .HALT_WORD(HALT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [2**D];

  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  typedef struct {
    logic [D-1:0] pc;
    logic [W-1:0] word;
  } fetch_t;

  fetch_t       inflight[$];
  bit           m_run, m_done, m_valid, m_zero_ir;
  logic [W-1:0] m_ir;
  logic [D-1:0] m_ipc;
  logic [D-1:0] pc;
  int           m_icnt, m_bcnt;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model, take the edge.
  task automatic cycle(input bit rst, input bit st, input bit jmp, input logic [D-1:0] tgt);
    bit     halt, kill, nvalid;
    fetch_t f;
    int     ei, eb;
    reset          = rst;
    bus.start      = st;
    bus.jump_taken = jmp;
    bus.pc_in      = pc;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    ei = m_icnt;
    eb = m_bcnt;
`else
    ei = 0;
    eb = 0;
`endif
    chk("imem_addr", 32'(bus.imem_addr), 32'(pc));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("instr_count", 32'(bus.instr_count), 32'(ei));
    chk("bubble_count", 32'(bus.bubble_count), 32'(eb));
    if (m_valid || m_zero_ir) begin
      chk("instr_out", 32'(bus.instr_out), 32'(m_ir));
      chk("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    end

    halt = m_run && m_valid && (m_ir == HALT);
    kill = rst || st || !m_run || jmp || halt;
    if (rst || st) begin
      m_icnt = 0;
      m_bcnt = 0;
    end else if (m_run) begin
      if (m_valid) m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : m_icnt;
      else         m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : m_bcnt;
    end
    nvalid = 1'b0;
    if (kill) begin
      inflight.delete();
    end else begin
      if (inflight.size() > 0) begin
        f      = inflight.pop_front();
        nvalid = 1'b1;
        m_ir   = f.word;
        m_ipc  = f.pc;
      end
      inflight.push_back('{pc: pc, word: mem[pc]});
    end
    m_valid   = nvalid;
    m_zero_ir = rst;
    if (rst) begin
      m_ir   = '0;
      m_ipc  = '0;
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (st) begin
      m_run  = 1'b1;
      m_done = 1'b0;
    end else if (halt) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end

    @(posedge clk);
    #1;
    if (rst || st)    pc = '0;
    else if (jmp)     pc = tgt;
    else              pc = pc + 1'b1;
  endtask

  // Run n cycles; optionally jump once when the IR holds a valid word at jpc.
  task automatic run(input int n, input int jpc, input logic [D-1:0] tgt);
    bit done_jump = 1'b0;
    bit j;
    for (int i = 0; i < n; i++) begin
      j = (jpc >= 0) && !done_jump && m_run && m_valid && (32'(m_ipc) == jpc);
      if (j) done_jump = 1'b1;
      cycle(1'b0, 1'b0, j, tgt);
    end
  endtask

  task automatic fill_nonzero(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) mem[a] = W'($urandom_range(2**W - 1, 1));
  endtask

  initial begin
    int seen_valid_pc3;
    pc             = '0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.jump_taken = 1'b0;
    bus.pc_in      = '0;
    m_run = 0; m_done = 0; m_valid = 0; m_zero_ir = 0;
    m_ir = '0; m_ipc = '0; m_icnt = 0; m_bcnt = 0;
    fill_nonzero(0, 2**D - 1);
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h044;
    mem[40] = 9'h155;

    // Reset, idle, then start with free-running PC.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("first_valid", 32'(bus.instr_valid), 32'd1);
    chk("first_pc", 32'(bus.instr_pc), 32'd0);
    chk("first_word", 32'(bus.instr_out), 32'h011);
    run(4, -1, '0);

    // Jump from pc 2 to 40; wrong-path pc 3 must never become valid.
    cycle(1'b0, 1'b1, 1'b0, '0);
    seen_valid_pc3 = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, m_valid && m_ipc == 2, D'(40));
      if (bus.instr_valid && bus.instr_pc == 3) seen_valid_pc3++;
    end
    chk("wrong_path_pc3", 32'(seen_valid_pc3), 32'd0);

    // Halt word at address 2.
    mem[2] = HALT;
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(8, -1, '0);
    chk("halt_done", 32'(bus.done), 32'd1);
`ifdef FETCH_PERF_EN
    chk("halt_icnt", 32'(bus.instr_count), 32'd3);
`endif

    // Jump together with halt detection: halt wins.
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(8, 2, D'(40));
    chk("halt_jump_done", 32'(bus.done), 32'd1);

    // Start from HALT, then reset together with start mid-run.
    mem[2] = 9'h033;
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(5, -1, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    run(3, -1, '0);
    chk("rst_start_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(4, -1, '0);

    // Long straight-line run saturates the 4-bit counter; jump near the top to cover wrap.
    fill_nonzero(0, 63);
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(24, -1, '0);
`ifdef FETCH_PERF_EN
    chk("icnt_sat", 32'(bus.instr_count), 32'd15);
`endif
    run(10, 20, D'(1022));

    // Random programs: random words, optional halt, random jumps, occasional reset.
    for (int p = 0; p < 25; p++) begin
      fill_nonzero(0, 63);
      if ($urandom_range(1, 0) == 1) mem[$urandom_range(40, 0)] = HALT;
      cycle($urandom_range(7, 0) == 0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 50; i++) begin
        cycle($urandom_range(99, 0) == 0, $urandom_range(59, 0) == 0,
              m_run && $urandom_range(5, 0) == 0, D'($urandom_range(63, 0)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
